serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial add/subtract unit built around a single full-adder cell and a registered carry. It sits directly downstream of the full-adder cell. It shifts operands through that cell one bit per clock, LSB first, and feeds the full-adder's carry-out back as the next bit's carry-in. It provides a low-area multi-cycle add/sub path for the CPU datapath, for example an area-reduced ALU variant or a multi-cycle helper.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous and active-high.
- start  input  1  request an operation; sampled only in IDLE or DONE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result is valid from this cycle on.
- sum  output  WIDTH  result register.
- cout  output  1  final carry-out of the MSB. For sub, 1 means no borrow (a >= b unsigned).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Internal state:
  - op_a, op_b: WIDTH-bit shift registers.
  - carry: 1-bit register.
  - acc: WIDTH-bit shift register for partial sums.
  - cnt: counter of width $clog2(WIDTH+1).
  - c_msb_in: 1-bit capture of the carry into the MSB.
  - Output registers: sum, cout, overflow.
- The datapath is one full-adder instance with inputs op_a[0], op_b[0], carry.
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on start = 1. Load:
  - op_a ← a
  - op_b ← sub ? ~b : b
  - carry ← sub
  - cnt ← 0
  - acc ← 0
- RUN, each cycle:
  - acc ← {fa_out, acc[WIDTH-1:1]}
  - op_a, op_b shift right by 1, zero-filled
  - carry ← fa_cout
  - cnt ← cnt + 1
  - When cnt = WIDTH-1, capture c_msb_in ← carry (pre-update value).
- RUN → DONE on the cycle where cnt = WIDTH-1, i.e. the last bit is processed. On that same edge:
  - sum ← {fa_out, acc[WIDTH-1:1]}
  - cout ← fa_cout
  - overflow ← carry ^ fa_cout
- DONE → IDLE if start = 0.
- DONE → RUN if start = 1. This is a back-to-back operation with the same load rules as from IDLE.
- start while in RUN is ignored. It is not queued, and operands and sub are not re-sampled.
- sum, cout and overflow change only at the RUN → DONE edge and otherwise hold. They are stable while busy from the previous result.
- Arithmetic is modulo 2^WIDTH. Results:
  - a+b: identical to a + b truncated to WIDTH bits.
  - a-b: identical to a + ~b + 1 truncated to WIDTH bits.

## Timing
- Reset (rst = 1 at a rising edge) forces state IDLE. It clears:
  - busy = 0, done = 0
  - sum = 0, cout = 0, overflow = 0
  - acc, op_a, op_b, carry, cnt
- Reset mid-RUN aborts the operation. No done is produced, and outputs read 0 the cycle after reset.
- Reset has priority over start in the same cycle.
- Latency, with start sampled high at edge E0:
  - busy is high from E0 through E_WIDTH, for exactly WIDTH cycles.
  - done is high for exactly one cycle, following edge E_WIDTH.
  - sum, cout and overflow are valid from that cycle.
- busy and done are never high together.
- Throughput:
  - Back-to-back (start held or re-asserted during DONE) gives one result per WIDTH+1 cycles.
  - From IDLE, the next start can be accepted at the earliest in the cycle after done.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset/idle, WIDTH=32: hold rst 3 cycles, then release with start=0 → busy=0, done=0, sum=0, cout=0, overflow=0, and they stay so for 50 cycles.
- Add latency, WIDTH=32: pulse start with a=0x0000_0005, b=0x0000_0007, sub=0 → busy high for exactly 32 cycles. Then done pulses once with sum=0x0000_000C, cout=0, overflow=0.
- Carry and overflow, WIDTH=32:
  - a=0xFFFF_FFFF, b=0x0000_0001, sub=0 → sum=0, cout=1, overflow=0.
  - a=0x7FFF_FFFF, b=1, sub=0 → sum=0x8000_0000, cout=0, overflow=1.
- Subtract, WIDTH=8:
  - a=0x05, b=0x07, sub=1 → sum=0xFE, cout=0, overflow=0.
  - a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, overflow=1.
- Ignore, hold and back-to-back, WIDTH=8:
  - Start 0x10+0x20.
  - Toggle start with different operands mid-RUN → ignored.
  - sum keeps the prior value until done, then 0x30.
  - Hold start=1 in DONE with 0x01+0x01 → busy rises the next cycle, then sum=0x02.
- Reset mid-op, WIDTH=32: assert rst at cycle 10 of RUN → no done pulse, all outputs 0. A fresh 3+4 then gives sum=7 with the full 32-cycle latency.
- Random check: 1000 random a/b/sub at WIDTH=32 and WIDTH=8 against a reference model, checking sum, cout and overflow.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract, one full-adder cell with a registered carry, LSB first.
module serial_adder_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, acc_q, acc_d, sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic             fa_s, fa_c, run, last, load;
   serial_adder_fa u_fa (
      .a_i(op_a_q[0]),
      .b_i(op_b_q[0]),
      .c_i(carry_q),
      .s_o(fa_s),
      .c_o(fa_c)
   );
   assign run  = state_q == RUN;
   assign last = run && cnt_q == CW'(WIDTH - 1);
   // start is only honoured outside RUN; mid-operation requests are dropped
   assign load = start && !run;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end
   always_comb begin
      state_d = load ? RUN : last ? DONE : run ? RUN : IDLE;
   end
   always_comb begin
      op_a_d  = load ? a : run ? op_a_q >> 1 : op_a_q;
      op_b_d  = load ? (sub ? ~b : b) : run ? op_b_q >> 1 : op_b_q;
      acc_d   = load ? '0 : run ? {fa_s, acc_q[WIDTH-1:1]} : acc_q;
      carry_d = load ? sub : run ? fa_c : carry_q;
      cnt_d   = load ? '0 : run ? cnt_q + CW'(1) : cnt_q;
      // carry_q is the carry into the MSB while the last bit is processed
      sum_d   = last ? {fa_s, acc_q[WIDTH-1:1]} : sum_q;
      cout_d  = last ? fa_c : cout_q;
      ovf_d   = last ? carry_q ^ fa_c : ovf_q;
   end
   always_comb begin
      busy     = state_q == RUN;
      done     = state_q == DONE;
      sum      = sum_q;
      cout     = cout_q;
      overflow = ovf_q;
   end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench driving 32-bit and 8-bit instances against an arithmetic model.
module tb_serial_adder;
   logic        clk = 1'b0, rst = 1'b1;
   logic        st32 = 1'b0, sb32 = 1'b0, bz32, dn32, co32, ov32;
   logic [31:0] a32 = '0, b32 = '0, sum32;
   logic        st8 = 1'b0, sb8 = 1'b0, bz8, dn8, co8, ov8;
   logic [7:0]  a8 = '0, b8 = '0, sum8;
   int          checks = 0, fails = 0, bc32 = 0, bc8 = 0;
   typedef struct {logic [63:0] s; logic c; logic o;} exp_t;
   exp_t        q32[$], q8[$];

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .start(st32), .sub(sb32), .a(a32), .b(b32),
      .busy(bz32), .done(dn32), .sum(sum32), .cout(co32), .overflow(ov32));
   serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(st8), .sub(sb8), .a(a8), .b(b8),
      .busy(bz8), .done(dn8), .sum(sum8), .cout(co8), .overflow(ov8));

   function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b, logic sub);
      logic [64:0] mask, aa, bb, t;
      exp_t e;
      mask = (65'd1 << w) - 65'd1;
      aa = {1'b0, a} & mask;
      bb = sub ? ~{1'b0, b} & mask : {1'b0, b} & mask;
      t = aa + bb + {64'd0, sub};
      e.s = t[63:0] & mask[63:0];
      e.c = t[w];
      e.o = (aa[w-1] == bb[w-1]) && (t[w-1] != aa[w-1]);
      return e;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst) bc32 = 0; else if (bz32) bc32++;
      if (!rst && dn32) begin
         check("busy_len32", 64'(bc32), 64'd32);
         check("busy_with_done32", {63'd0, bz32}, 64'd0);
         bc32 = 0;
         if (q32.size() == 0) check("spurious_done32", {63'd0, dn32}, 64'd0);
         else begin
            e = q32.pop_front();
            check("sum32", {32'd0, sum32}, e.s);
            check("cout32", {63'd0, co32}, {63'd0, e.c});
            check("ovf32", {63'd0, ov32}, {63'd0, e.o});
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) bc8 = 0; else if (bz8) bc8++;
      if (!rst && dn8) begin
         check("busy_len8", 64'(bc8), 64'd8);
         check("busy_with_done8", {63'd0, bz8}, 64'd0);
         bc8 = 0;
         if (q8.size() == 0) check("spurious_done8", {63'd0, dn8}, 64'd0);
         else begin
            e = q8.pop_front();
            check("sum8", {56'd0, sum8}, e.s);
            check("cout8", {63'd0, co8}, {63'd0, e.c});
            check("ovf8", {63'd0, ov8}, {63'd0, e.o});
         end
      end
   end

   task automatic drive(int w, logic [63:0] a, logic [63:0] b, logic sub);
      if (w == 32) begin
         st32 = 1'b1; a32 = a[31:0]; b32 = b[31:0]; sb32 = sub;
         q32.push_back(model(32, a, b, sub));
      end else begin
         st8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; sb8 = sub;
         q8.push_back(model(8, a, b, sub));
      end
   endtask

   task automatic go(int w, logic [63:0] a, logic [63:0] b, logic sub);
      @(negedge clk);
      drive(w, a, b, sub);
      @(negedge clk);
      st32 = 1'b0; st8 = 1'b0;
   endtask

   task automatic wait_done(int w);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (w == 32 ? dn32 : dn8) return;
      end
      checks++; fails++;
      $display("FAIL timeout_done%0d: no done within 200 cycles, required done=1", w);
   endtask

   task automatic dchk(string name, int w, logic [63:0] s, logic c, logic o);
      check(name, w == 32 ? {32'd0, sum32, co32, ov32} : {56'd0, sum8, co8, ov8}, {s, c, o});
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("idle32", {bz32, dn32, sum32, co32, ov32}, 64'd0);
         check("idle8", {bz8, dn8, sum8, co8, ov8}, 64'd0);
      end
      go(32, 64'h5, 64'h7, 1'b0);              wait_done(32); dchk("add_5_7", 32, 64'hC, 1'b0, 1'b0);
      go(32, 64'hFFFF_FFFF, 64'h1, 1'b0);      wait_done(32); dchk("add_carry", 32, 64'h0, 1'b1, 1'b0);
      go(32, 64'h7FFF_FFFF, 64'h1, 1'b0);      wait_done(32); dchk("add_ovf", 32, 64'h8000_0000, 1'b0, 1'b1);
      go(8, 64'h05, 64'h07, 1'b1);             wait_done(8);  dchk("sub_5_7", 8, 64'hFE, 1'b0, 1'b0);
      go(8, 64'h80, 64'h01, 1'b1);             wait_done(8);  dchk("sub_80_1", 8, 64'h7F, 1'b1, 1'b1);
      go(8, 64'h10, 64'h20, 1'b0);
      repeat (2) @(negedge clk);
      st8 = 1'b1; a8 = 8'hAA; b8 = 8'h33; sb8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      check("hold_sum8", {56'd0, sum8}, 64'h7F);
      wait_done(8);
      dchk("ignore_result", 8, 64'h30, 1'b0, 1'b0);
      drive(8, 64'h01, 64'h01, 1'b0);
      @(negedge clk);
      check("b2b_busy", {63'd0, bz8}, 64'd1);
      check("b2b_hold_sum", {56'd0, sum8}, 64'h30);
      st8 = 1'b0;
      wait_done(8);
      dchk("b2b_result", 8, 64'h02, 1'b0, 1'b0);
      @(negedge clk);
      st32 = 1'b1; a32 = 32'h1234; b32 = 32'h4321; sb32 = 1'b0;
      @(negedge clk);
      st32 = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_outputs", {bz32, dn32, sum32, co32, ov32}, 64'd0);
      repeat (40) @(negedge clk);
      go(32, 64'h3, 64'h4, 1'b0);              wait_done(32); dchk("after_abort", 32, 64'h7, 1'b0, 1'b0);
      for (int i = 0; i < 1000; i++) begin
         go(32, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)));
         wait_done(32);
         go(8, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)));
         wait_done(8);
      end
      repeat (3) @(negedge clk);
      check("q32_drained", 64'(q32.size()), 64'd0);
      check("q8_drained", 64'(q8.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
